// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network layer blocks.
//   state_t    : layer sequencer states
//   ACC_MAX    : widest accumulator that sat_round can handle
//   acc_width  : accumulator width that makes a MAC chain overflow-free
//   sat_round  : round-half-up, shift out fraction, saturate to Q_SIZE
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        BIAS,
        DONE
    } state_t;

    localparam int ACC_MAX = 128;

    // Full product (2*q_size) plus growth for input_size terms plus a guard bit.
    function automatic int acc_width(input int q_size, input int input_size);
        return 2 * q_size + $clog2(input_size) + 1;
    endfunction

    // Returns a value already clamped to the signed q_size range, carried in
    // ACC_MAX bits so callers can narrow it with a plain size cast.
    function automatic logic signed [ACC_MAX-1:0] sat_round(
        input logic signed [ACC_MAX-1:0] acc,
        input int                        q_size,
        input int                        q_frac
    );
        logic signed [ACC_MAX-1:0] one;
        logic signed [ACC_MAX-1:0] half;
        logic signed [ACC_MAX-1:0] shifted;
        logic signed [ACC_MAX-1:0] max_v;
        logic signed [ACC_MAX-1:0] min_v;
        one     = {{(ACC_MAX-1){1'b0}}, 1'b1};
        half    = (q_frac > 0) ? (one <<< (q_frac - 1)) : '0;
        shifted = (acc + half) >>> q_frac;
        max_v   = (one <<< (q_size - 1)) - one;
        min_v   = -(one <<< (q_size - 1));
        if (shifted > max_v)
            return max_v;
        else if (shifted < min_v)
            return min_v;
        else
            return shifted;
    endfunction

endpackage

// File: rtl/mac_neuron.sv
// One output neuron of the fully-connected layer.
//   clear    : load acc with serial_in*weight (first element of a vector)
//   accum    : add serial_in*weight to acc
//   finish   : add bias, round, saturate, optional ReLU, register to result
//   serial_in, weight, bias : signed Q-format words
//   relu_en  : clamp negative results to zero (sampled with finish)
//   result   : registered neuron output
module mac_neuron
    import nn_pkg::*;
#(
    parameter int Q_SIZE = 16,
    parameter int Q_FRAC = 8,
    parameter int ACC_W  = 35
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     accum,
    input  logic                     finish,
    input  logic signed [Q_SIZE-1:0] serial_in,
    input  logic signed [Q_SIZE-1:0] weight,
    input  logic signed [Q_SIZE-1:0] bias,
    input  logic                     relu_en,
    output logic signed [Q_SIZE-1:0] result
);

    logic signed [2*Q_SIZE-1:0]  prod_p0;
    logic signed [ACC_W-1:0]     prod_ext;
    logic signed [ACC_W-1:0]     acc_p1;
    logic signed [ACC_W-1:0]     bias_sh;
    logic signed [ACC_W-1:0]     biased;
    logic signed [ACC_MAX-1:0]   rounded;
    logic signed [Q_SIZE-1:0]    res_next;

    assign prod_p0  = serial_in * weight;
    assign prod_ext = ACC_W'(prod_p0);
    // Bias is a Q-format value; align it with the 2*Q_FRAC product scale.
    assign bias_sh  = ACC_W'(bias) <<< Q_FRAC;
    assign biased   = acc_p1 + bias_sh;
    assign rounded  = sat_round(ACC_MAX'(biased), Q_SIZE, Q_FRAC);
    assign res_next = (relu_en && rounded < 0) ? '0 : Q_SIZE'(rounded);

    // ---- accumulate stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_p1 <= '0;
        else if (clear)
            acc_p1 <= prod_ext;
        else if (accum)
            acc_p1 <= acc_p1 + prod_ext;
    end

    // ---- output stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            result <= '0;
        else if (finish)
            result <= res_next;
    end

endmodule

// File: rtl/mac_layer.sv
// Fully-connected layer engine fed by an upstream Serializer.
//   start             : request to process a new vector (ignored while busy)
//   serial_in         : current activation from the Serializer
//   weight_in         : OUTPUT_SIZE weights for element weight_addr
//   bias_in, relu_en  : per-neuron bias and ReLU enable, used in BIAS
//   serializer_update : load pulse to the Serializer (LOAD)
//   serializer_shift  : shift enable to the Serializer (STREAM)
//   weight_addr       : index of the element on serial_in
//   busy              : high LOAD..BIAS
//   data_out          : registered result vector
//   data_valid        : one-cycle pulse when data_out updates
module mac_layer
    import nn_pkg::*;
#(
    parameter int INPUT_SIZE  = 4,
    parameter int OUTPUT_SIZE = 4,
    parameter int Q_SIZE      = 16,
    parameter int Q_FRAC      = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic signed [Q_SIZE-1:0]          serial_in,
    input  logic [OUTPUT_SIZE*Q_SIZE-1:0]     weight_in,
    input  logic [OUTPUT_SIZE*Q_SIZE-1:0]     bias_in,
    input  logic                              relu_en,
    output logic                              serializer_update,
    output logic                              serializer_shift,
    output logic [$clog2(INPUT_SIZE)-1:0]     weight_addr,
    output logic                              busy,
    output logic [OUTPUT_SIZE*Q_SIZE-1:0]     data_out,
    output logic                              data_valid
);

    localparam int ADDR_W = $clog2(INPUT_SIZE);
    localparam int ACC_W  = acc_width(Q_SIZE, INPUT_SIZE);

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == LOAD)
                cnt <= ADDR_W'(1);
            else if (state == STREAM)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = STREAM;
            STREAM:  if (cnt == ADDR_W'(INPUT_SIZE - 1)) next_state = BIAS;
            BIAS:    next_state = DONE;
            DONE:    next_state = start ? LOAD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        serializer_update = 1'b0;
        serializer_shift  = 1'b0;
        weight_addr       = '0;
        busy              = 1'b0;
        data_valid        = 1'b0;
        case (state)
            LOAD: begin
                serializer_update = 1'b1;
                busy              = 1'b1;
            end
            STREAM: begin
                serializer_shift = 1'b1;
                weight_addr      = cnt;
                busy             = 1'b1;
            end
            BIAS:    busy       = 1'b1;
            DONE:    data_valid = 1'b1;
            default: ;
        endcase
    end

    for (genvar j = 0; j < OUTPUT_SIZE; j++) begin : g_neuron
        mac_neuron #(
            .Q_SIZE (Q_SIZE),
            .Q_FRAC (Q_FRAC),
            .ACC_W  (ACC_W)
        ) u_neuron (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (state == LOAD),
            .accum     (state == STREAM),
            .finish    (state == BIAS),
            .serial_in (serial_in),
            .weight    (weight_in[j*Q_SIZE +: Q_SIZE]),
            .bias      (bias_in[j*Q_SIZE +: Q_SIZE]),
            .relu_en   (relu_en),
            .result    (data_out[j*Q_SIZE +: Q_SIZE])
        );
    end

endmodule

// File: tb/tb_mac_layer.sv
// Directed bench for mac_layer (INPUT_SIZE=4, OUTPUT_SIZE=4, Q8.8).
// The bench plays the upstream Serializer and weight memory: serial_in and
// weight_in follow weight_addr combinationally.
module tb_mac_layer;

    localparam int IN_N  = 4;
    localparam int OUT_N = 4;
    localparam int Q     = 16;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic signed [Q-1:0]   serial_in;
    logic [OUT_N*Q-1:0]    weight_in;
    logic [OUT_N*Q-1:0]    bias_in;
    logic                  relu_en;
    logic                  serializer_update;
    logic                  serializer_shift;
    logic [1:0]            weight_addr;
    logic                  busy;
    logic [OUT_N*Q-1:0]    data_out;
    logic                  data_valid;

    logic signed [Q-1:0]   xv [IN_N];
    logic signed [Q-1:0]   wv [OUT_N][IN_N];
    logic signed [Q-1:0]   bv [OUT_N];
    longint                exp_v [OUT_N];

    int n_checks = 0;
    int n_fail   = 0;

    mac_layer #(
        .INPUT_SIZE  (IN_N),
        .OUTPUT_SIZE (OUT_N),
        .Q_SIZE      (Q),
        .Q_FRAC      (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .serial_in         (serial_in),
        .weight_in         (weight_in),
        .bias_in           (bias_in),
        .relu_en           (relu_en),
        .serializer_update (serializer_update),
        .serializer_shift  (serializer_shift),
        .weight_addr       (weight_addr),
        .busy              (busy),
        .data_out          (data_out),
        .data_valid        (data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        serial_in = xv[weight_addr];
        weight_in = '0;
        bias_in   = '0;
        for (int j = 0; j < OUT_N; j++) begin
            weight_in[j*Q +: Q] = wv[j][weight_addr];
            bias_in[j*Q +: Q]   = bv[j];
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint lane(input int j);
        logic signed [Q-1:0] v;
        v = data_out[j*Q +: Q];
        return longint'(v);
    endfunction

    // One vector: start at edge 0, observe cycles 1..10 at #1 after each edge.
    task automatic run_vec(input string tag, input bit mid_start);
        int     dv_cyc;
        int     n_dv;
        int     n_upd;
        int     n_shf;
        int     bad_ctl;
        longint got [OUT_N];
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        dv_cyc  = 0;
        n_dv    = 0;
        n_upd   = 0;
        n_shf   = 0;
        bad_ctl = 0;
        for (int j = 0; j < OUT_N; j++) got[j] = 0;
        for (int c = 1; c <= 10; c++) begin
            if (serializer_update) begin
                n_upd++;
                if (c != 1 || weight_addr != 2'd0) bad_ctl++;
            end
            if (serializer_shift) begin
                n_shf++;
                if (weight_addr != 2'(c - 1)) bad_ctl++;
            end
            if (serializer_update && serializer_shift) bad_ctl++;
            if (busy != (c >= 1 && c <= 5)) bad_ctl++;
            if (data_valid) begin
                n_dv++;
                if (dv_cyc == 0) begin
                    dv_cyc = c;
                    for (int j = 0; j < OUT_N; j++) got[j] = lane(j);
                end
            end
            if (mid_start) start = (c == 3);
            if (c < 10) begin
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, dv_cyc, 6);
        chk({tag, "_valid_pulses"}, n_dv, 1);
        chk({tag, "_update_cycles"}, n_upd, 1);
        chk({tag, "_shift_cycles"}, n_shf, IN_N - 1);
        chk({tag, "_ctl_seq_errors"}, bad_ctl, 0);
        for (int j = 0; j < OUT_N; j++)
            chk($sformatf("%s_out%0d", tag, j), got[j], exp_v[j]);
    endtask

    task automatic load_identity();
        xv = '{256, 256, 256, 256};
        wv = '{'{256, 256, 256, 256}, '{-128, -128, -128, -128},
               '{512, 0, 0, 0}, '{0, 0, 0, 0}};
        bv = '{0, 0, 100, -5};
        relu_en = 1'b0;
        exp_v = '{1024, -512, 612, -5};
    endtask

    initial begin
        int     dv_list [$];
        longint second_out0;
        rst_n = 1'b0;
        start = 1'b0;
        load_identity();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", longint'(data_out), 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ctl", {serializer_update, serializer_shift, weight_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec("identity", 1'b0);

        xv = '{256, 512, -256, 0};
        wv = '{'{256, 256, 256, 256}, '{0, 256, 0, 0},
               '{-256, -256, -256, -256}, '{128, 128, 128, 128}};
        bv = '{128, 0, 0, 0};
        exp_v = '{640, 512, -512, 256};
        run_vec("mixed", 1'b0);

        xv = '{32767, 32767, 32767, 32767};
        for (int j = 0; j < OUT_N; j++) begin
            wv[j] = '{32767, 32767, 32767, 32767};
            bv[j] = 0;
        end
        exp_v = '{32767, 32767, 32767, 32767};
        run_vec("sat_pos", 1'b0);

        xv = '{-32768, -32768, -32768, -32768};
        exp_v = '{-32768, -32768, -32768, -32768};
        run_vec("sat_neg", 1'b0);
        relu_en = 1'b1;
        exp_v = '{0, 0, 0, 0};
        run_vec("sat_neg_relu", 1'b0);

        xv = '{256, 0, 0, 0};
        wv = '{'{-300, 0, 0, 0}, '{300, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        bv = '{0, 0, 0, 0};
        relu_en = 1'b1;
        exp_v = '{0, 300, 0, 0};
        run_vec("relu_on", 1'b0);
        relu_en = 1'b0;
        exp_v = '{-300, 300, 0, 0};
        run_vec("relu_off", 1'b0);

        xv = '{1, 0, 0, 0};
        wv = '{'{128, 0, 0, 0}, '{127, 0, 0, 0}, '{-128, 0, 0, 0}, '{-129, 0, 0, 0}};
        exp_v = '{1, 0, 0, -1};
        run_vec("round", 1'b0);

        load_identity();
        run_vec("start_in_stream", 1'b1);

        // Back-to-back: start held so the DONE-cycle request is accepted.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        second_out0 = 0;
        for (int c = 1; c <= 14; c++) begin
            if (data_valid) begin
                dv_list.push_back(c);
                if (c == 12) second_out0 = lane(0);
            end
            if (c == 7) start = 1'b0;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk("b2b_valid_count", dv_list.size(), 2);
        chk("b2b_first", (dv_list.size() > 0) ? dv_list[0] : -1, 6);
        chk("b2b_second", (dv_list.size() > 1) ? dv_list[1] : -1, 12);
        chk("b2b_out0", second_out0, 1024);

        // Asynchronous reset while streaming.
        begin
            int n_dv;
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk("pre_rst_shift", serializer_shift, 1);
            rst_n = 1'b0;
            #1;
            chk("mid_rst_data_out", longint'(data_out), 0);
            chk("mid_rst_ctl", {busy, data_valid, serializer_update, serializer_shift}, 0);
            chk("mid_rst_addr", weight_addr, 0);
            @(negedge clk);
            rst_n = 1'b1;
            n_dv = 0;
            for (int c = 0; c < 8; c++) begin
                @(posedge clk);
                #1;
                if (data_valid || busy) n_dv++;
            end
            chk("post_rst_idle", n_dv, 0);
        end
        run_vec("after_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
